// File: rtl/fireball_motion_control.sv
// Life cycle and screen position of one player fireball:
// launch, horizontal flight, end on hit/edge, then re-fire cooldown.
module fireball_motion_control #(
  parameter int X_WIDTH         = 10,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int SPEED           = 4,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               fire,
  input  logic               facing,
  input  logic [X_WIDTH-1:0] launch_x,
  input  logic [X_WIDTH-1:0] launch_y,
  input  logic               hit,
  output logic               is_active,
  output logic [X_WIDTH-1:0] fireball_x,
  output logic [X_WIDTH-1:0] fireball_y,
  output logic               busy
);

  localparam int CW = (COOLDOWN_FRAMES > 0) ?
                      $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam int SW = X_WIDTH + 2;

  localparam logic [CW-1:0]        CD_INIT = CW'(COOLDOWN_FRAMES);
  localparam logic [X_WIDTH-1:0]   SPD_N   = X_WIDTH'(SPEED);
  localparam logic [X_WIDTH:0]     SPD_E   = (X_WIDTH+1)'(SPEED);
  localparam logic [X_WIDTH:0]     MAX_E   = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0]     LEFT_E  = (X_WIDTH+1)'(X_MIN + SPEED);
  localparam logic signed [SW-1:0] MIN_S   = SW'(X_MIN);
  localparam logic signed [SW-1:0] MAX_S   = SW'(X_MAX);
  localparam logic [X_WIDTH-1:0]   MIN_N   = X_WIDTH'(X_MIN);
  localparam logic [X_WIDTH-1:0]   MAX_N   = X_WIDTH'(X_MAX);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    FLIGHT,
    COOLDOWN
  } state_t;

  state_t             state;
  logic [X_WIDTH-1:0] x;
  logic [X_WIDTH-1:0] y;
  logic               dir;
  logic [CW-1:0]      cnt;

  logic signed [SW-1:0] lx_s;
  logic [X_WIDTH-1:0]   lx_clamped;
  logic [X_WIDTH:0]     x_e;
  logic                 at_edge;
  logic [X_WIDTH-1:0]   x_next;

  always_comb begin
    lx_s = signed'({2'b00, launch_x});
    if (lx_s < MIN_S)
      lx_clamped = MIN_N;
    else if (lx_s > MAX_S)
      lx_clamped = MAX_N;
    else
      lx_clamped = launch_x;
  end

  // One extra bit so the edge test never wraps.
  always_comb begin
    x_e     = {1'b0, x};
    at_edge = dir ? ((x_e + SPD_E) > MAX_E)
                  : (x_e < LEFT_E);
    x_next  = dir ? (x + SPD_N) : (x - SPD_N);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      dir   <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            state <= LAUNCH;
            x     <= lx_clamped;
            y     <= launch_y;
            dir   <= facing;
          end
        end
        LAUNCH: begin
          if (hit) begin
            state <= COOLDOWN;
            cnt   <= CD_INIT;
          end else if (frame_tick) begin
            state <= FLIGHT;
          end
        end
        FLIGHT: begin
          if (hit || (frame_tick && at_edge)) begin
            state <= COOLDOWN;
            cnt   <= CD_INIT;
          end else if (frame_tick) begin
            x <= x_next;
          end
        end
        COOLDOWN: begin
          if (cnt == '0)
            state <= IDLE;
          else if (frame_tick)
            cnt <= cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign is_active  = (state == LAUNCH) || (state == FLIGHT);
  assign busy       = (state != IDLE);
  assign fireball_x = x;
  assign fireball_y = y;

endmodule

// File: tb/tb_fireball_motion_control.sv
// Scoreboard bench: two parameterisations driven in lock-step,
// expected outputs from a behavioural model pushed per cycle.
module tb_fireball_motion_control;

  localparam int W = 10;

  logic         Clk = 1'b0;
  logic         Reset_n;
  logic         frame_tick;
  logic         fire;
  logic         facing;
  logic [W-1:0] launch_x;
  logic [W-1:0] launch_y;
  logic         hit;

  logic         act_a, busy_a, act_b, busy_b;
  logic [W-1:0] x_a, y_a, x_b, y_b;

  always #5 Clk = ~Clk;

  fireball_motion_control u_a (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .fire       (fire),
    .facing     (facing),
    .launch_x   (launch_x),
    .launch_y   (launch_y),
    .hit        (hit),
    .is_active  (act_a),
    .fireball_x (x_a),
    .fireball_y (y_a),
    .busy       (busy_a)
  );

  fireball_motion_control #(
    .X_MIN           (16),
    .X_MAX           (600),
    .SPEED           (5),
    .COOLDOWN_FRAMES (0)
  ) u_b (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .frame_tick (frame_tick),
    .fire       (fire),
    .facing     (facing),
    .launch_x   (launch_x),
    .launch_y   (launch_y),
    .hit        (hit),
    .is_active  (act_b),
    .fireball_x (x_b),
    .fireball_y (y_b),
    .busy       (busy_b)
  );

  // Behavioural view: alive ball, whether it has started moving,
  // and remaining cooldown frames (-1 when not cooling down).
  typedef struct {
    bit alive;
    bit moving;
    int cool;
    int x;
    int y;
    bit dir;
  } ball_t;

  typedef struct packed {
    logic [2*W+1:0] a;
    logic [2*W+1:0] b;
  } exp_t;

  ball_t ma, mb;
  exp_t  q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic ball_t step(ball_t m, int cd, int xmin,
                                 int xmax, int spd, bit rst,
                                 bit f, bit t, bit h, bit fc,
                                 int lx, int ly);
    ball_t n = m;
    int    nx;
    if (rst) begin
      n.alive = 0; n.moving = 0; n.cool = -1;
      n.x = 0; n.y = 0; n.dir = 0;
    end else if (m.cool >= 0) begin
      if (m.cool == 0) n.cool = -1;
      else if (t) n.cool = m.cool - 1;
    end else if (!m.alive) begin
      if (f) begin
        n.alive = 1; n.moving = 0;
        n.x = (lx < xmin) ? xmin : (lx > xmax) ? xmax : lx;
        n.y = ly; n.dir = fc;
      end
    end else if (h) begin
      n.alive = 0; n.cool = cd;
    end else if (t) begin
      if (!m.moving) begin
        n.moving = 1;
      end else begin
        nx = m.dir ? m.x + spd : m.x - spd;
        if (nx > xmax || nx < xmin) begin
          n.alive = 0; n.cool = cd;
        end else begin
          n.x = nx;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [2*W+1:0] view(ball_t m);
    logic bz;
    bz = m.alive || (m.cool >= 0);
    return {m.alive, bz, W'(m.x), W'(m.y)};
  endfunction

  task automatic cyc(bit rst_n, bit f, bit t, bit h, bit fc,
                     int lx, int ly);
    exp_t e;
    Reset_n    = rst_n;
    fire       = f;
    frame_tick = t;
    hit        = h;
    facing     = fc;
    launch_x   = W'(lx);
    launch_y   = W'(ly);
    ma = step(ma, 30, 0, 639, 4, !rst_n, f, t, h, fc, lx, ly);
    mb = step(mb, 0, 16, 600, 5, !rst_n, f, t, h, fc, lx, ly);
    e.a = view(ma);
    e.b = view(mb);
    q.push_back(e);
    @(negedge Clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(int n, bit h);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 1, h, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0);
    end
  endtask

  // Monitor: each cycle's outputs are compared one edge later.
  always begin
    exp_t e;
    logic [2*W+1:0] got;
    @(posedge Clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {act_a, busy_a, x_a, y_a};
      checks++;
      if (got === e.a) passed++;
      else $display("FAIL dut_a t=%0t act/busy/x/y got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                    $time, got[2*W+1], got[2*W], got[2*W-1:W], got[W-1:0],
                    e.a[2*W+1], e.a[2*W], e.a[2*W-1:W], e.a[W-1:0]);
      got = {act_b, busy_b, x_b, y_b};
      checks++;
      if (got === e.b) passed++;
      else $display("FAIL dut_b t=%0t act/busy/x/y got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                    $time, got[2*W+1], got[2*W], got[2*W-1:W], got[W-1:0],
                    e.b[2*W+1], e.b[2*W], e.b[2*W-1:W], e.b[W-1:0]);
    end
  end

  initial begin
    ma = '{0, 0, -1, 0, 0, 0};
    mb = '{0, 0, -1, 0, 0, 0};
    // Reset with fire and hit asserted, then launch right away.
    cyc(0, 1, 0, 1, 1, 50, 60);
    cyc(0, 1, 0, 1, 1, 50, 60);
    cyc(1, 1, 0, 0, 1, 50, 60);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Straight flight to the right.
    cyc(1, 1, 0, 0, 1, 100, 200);
    idle(2);
    ticks(3, 0);
    cyc(1, 0, 0, 1, 0, 0, 0);
    ticks(32, 0);
    idle(2);
    // Right edge.
    cyc(1, 1, 0, 0, 1, 632, 10);
    ticks(4, 0);
    ticks(31, 0);
    idle(2);
    // Left edge, no underflow.
    cyc(1, 1, 0, 0, 0, 5, 20);
    ticks(4, 0);
    ticks(31, 0);
    idle(2);
    // Hit coincident with a tick, then hit while idle.
    cyc(1, 1, 0, 0, 1, 300, 30);
    ticks(1, 0);
    ticks(1, 1);
    ticks(31, 0);
    idle(2);
    cyc(1, 0, 0, 1, 0, 0, 0);
    ticks(1, 1);
    // Held fire with clamped launch points, then mid-flight reset.
    for (int i = 0; i < 80; i++)
      cyc(1, 1, i[0], 0, 1, 1000, 40);
    cyc(1, 1, 1, 0, 0, 3, 41);
    ticks(3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Random traffic.
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(299, 0) != 0,
          $urandom_range(3, 0) == 0,
          $urandom_range(1, 0) == 1,
          $urandom_range(39, 0) == 0,
          $urandom_range(1, 0) == 1,
          $urandom_range(1023, 0),
          $urandom_range(479, 0));
    repeat (3) @(posedge Clk);
    #3;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain left %0d want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
